// File: rtl/process_pkg.sv
// Shared types and defaults for the compress/decompress sequencer.
package process_pkg;

  typedef enum logic [3:0] {
    S_IDLE, S_ACK, S_RST_M, S_START_M, S_WAIT_M,
    S_RST_I, S_START_I, S_WAIT_I, S_NEXT, S_DONE, S_ERR
  } state_e;

  localparam logic [1:0] MODE_MDCT  = 2'b00;
  localparam logic [1:0] MODE_IMDCT = 2'b01;
  localparam logic [1:0] MODE_BOTH  = 2'b10;

  localparam int DEF_ADDR_W       = 14;
  localparam int DEF_FRM_W        = 8;
  localparam int DEF_NUM_CH       = 2;
  localparam int DEF_FRAME_STRIDE = 256;
  localparam int DEF_RST_CYC      = 4;
  localparam int DEF_TO_W         = 16;

  // Stage slots in the per-stage packed vectors.
  localparam int STG_M   = 0;
  localparam int STG_I   = 1;
  localparam int NUM_STG = 2;

endpackage

// File: rtl/stage_handshake.sv
// Per-stage handshake: reset-hold timing, start pulse, finish edge and watchdog.
module stage_handshake #(
  parameter int RST_CYC = 4,
  parameter int TO_W    = 16
) (
  input  logic clk_in,
  input  logic rst_n,
  input  logic hold_rst,
  input  logic fire,
  input  logic waiting,
  input  logic finish,
  output logic rst_done,
  output logic start,
  output logic rstn,
  output logic fin_rise,
  output logic timeout
);

  localparam int RW = $clog2(RST_CYC) + 1;

  logic [RW-1:0]   rst_cnt;
  logic [TO_W-1:0] to_cnt;
  logic            fin_q;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      rst_cnt <= '0;
      to_cnt  <= '0;
      fin_q   <= 1'b0;
    end else begin
      fin_q   <= finish;
      rst_cnt <= hold_rst ? rst_cnt + RW'(1) : '0;
      to_cnt  <= waiting ? to_cnt + TO_W'(1) : '0;
    end
  end

  assign rst_done = hold_rst && (rst_cnt == RW'(RST_CYC - 1));
  assign start    = fire;
  assign rstn     = fire | waiting;
  assign fin_rise = waiting & finish & ~fin_q;
  // Fires in the wait cycle where the counter would reach all-ones.
  assign timeout  = waiting && (to_cnt == {{(TO_W-1){1'b1}}, 1'b0});

endmodule

// File: rtl/process_seq.sv
// Multi-frame, multi-channel sequencer driving the mdct/imdct stages.
module process_seq
  import process_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int FRM_W        = DEF_FRM_W,
  parameter int NUM_CH       = DEF_NUM_CH,
  parameter int FRAME_STRIDE = DEF_FRAME_STRIDE,
  parameter int RST_CYC      = DEF_RST_CYC,
  parameter int TO_W         = DEF_TO_W
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic              start_sys,
  input  logic              intr_clr_sys,
  input  logic              abort_sys,
  input  logic [ADDR_W-1:0] start_music_addr,
  input  logic [FRM_W-1:0]  num_frames,
  input  logic [1:0]        mode,
  output logic              start_clr_sys,
  output logic              intr_sys,
  output logic              err_sys,
  output logic              busy,
  output logic [FRM_W-1:0]  frame_idx,
  output logic [2:0]        ch_idx,
  output logic              start_mdct,
  output logic [ADDR_W-1:0] start_music_addr_r,
  input  logic              finish_mdct,
  output logic              rstn_mdct,
  output logic              start_imdct,
  input  logic              finish_imdct,
  output logic              rstn_imdct
);

  state_e state, state_nx;

  logic [ADDR_W-1:0] base_r;
  logic [FRM_W-1:0]  num_r;
  logic [1:0]        mode_r;
  logic [ADDR_W-1:0] chf_off;
  logic              last_ch;

  logic [NUM_STG-1:0] hold, fire, waiting, finish, rst_done, stg_start, stg_rstn, fin_rise, timeout;

  assign hold    = {state == S_RST_I,   state == S_RST_M};
  assign fire    = {state == S_START_I, state == S_START_M};
  assign waiting = {state == S_WAIT_I,  state == S_WAIT_M};
  assign finish  = {finish_imdct, finish_mdct};

  for (genvar g = 0; g < NUM_STG; g++) begin : g_stg
    stage_handshake #(.RST_CYC(RST_CYC), .TO_W(TO_W)) u_hs (
      .clk_in   (clk_in),
      .rst_n    (rst_n),
      .hold_rst (hold[g]),
      .fire     (fire[g]),
      .waiting  (waiting[g]),
      .finish   (finish[g]),
      .rst_done (rst_done[g]),
      .start    (stg_start[g]),
      .rstn     (stg_rstn[g]),
      .fin_rise (fin_rise[g]),
      .timeout  (timeout[g])
    );
  end

  assign start_mdct    = stg_start[STG_M];
  assign start_imdct   = stg_start[STG_I];
  assign rstn_mdct     = stg_rstn[STG_M];
  assign rstn_imdct    = stg_rstn[STG_I];
  assign start_clr_sys = (state == S_ACK);
  assign busy          = !(state inside {S_IDLE, S_DONE, S_ERR});
  assign last_ch       = (ch_idx == 3'(NUM_CH - 1));
  // ROM offset of the current channel-frame; wraps with the address width.
  assign chf_off = ADDR_W'((32'(frame_idx) * 32'(NUM_CH) + 32'(ch_idx)) * 32'(FRAME_STRIDE));

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:    if (start_sys) state_nx = S_ACK;
      S_ACK: begin
        if (!(mode inside {MODE_MDCT, MODE_IMDCT, MODE_BOTH})) state_nx = S_ERR;
        else if (num_frames == '0)                             state_nx = S_DONE;
        else if (mode == MODE_IMDCT)                           state_nx = S_RST_I;
        else                                                   state_nx = S_RST_M;
      end
      S_RST_M:   if (rst_done[STG_M]) state_nx = S_START_M;
      S_START_M: state_nx = S_WAIT_M;
      S_WAIT_M: begin
        if (timeout[STG_M])       state_nx = S_ERR;
        else if (fin_rise[STG_M]) state_nx = (mode_r == MODE_BOTH) ? S_RST_I : S_NEXT;
      end
      S_RST_I:   if (rst_done[STG_I]) state_nx = S_START_I;
      S_START_I: state_nx = S_WAIT_I;
      S_WAIT_I: begin
        if (timeout[STG_I])       state_nx = S_ERR;
        else if (fin_rise[STG_I]) state_nx = S_NEXT;
      end
      S_NEXT: begin
        if (last_ch && frame_idx == num_r - FRM_W'(1)) state_nx = S_DONE;
        else state_nx = (mode_r == MODE_IMDCT) ? S_RST_I : S_RST_M;
      end
      S_DONE, S_ERR: if (intr_clr_sys) state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
    if (abort_sys && busy) state_nx = S_IDLE;
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state              <= S_IDLE;
      base_r             <= '0;
      num_r              <= '0;
      mode_r             <= '0;
      frame_idx          <= '0;
      ch_idx             <= '0;
      start_music_addr_r <= '0;
      intr_sys           <= 1'b0;
      err_sys            <= 1'b0;
    end else begin
      state <= state_nx;
      // Flags follow the terminal states, so an entry always beats a same-cycle clear.
      intr_sys <= (state_nx inside {S_DONE, S_ERR});
      err_sys  <= (state_nx == S_ERR);
      if (state == S_ACK) begin
        base_r    <= start_music_addr;
        num_r     <= num_frames;
        mode_r    <= mode;
        frame_idx <= '0;
        ch_idx    <= '0;
      end
      if (state == S_NEXT) begin
        if (last_ch) begin
          ch_idx    <= '0;
          frame_idx <= frame_idx + FRM_W'(1);
        end else begin
          ch_idx <= ch_idx + 3'd1;
        end
      end
      if (|hold) start_music_addr_r <= base_r + chf_off;
    end
  end

endmodule

// File: tb/tb_process_seq.sv
// Randomised bench for process_seq against a frame/channel event-list model.
module tb_process_seq;
  import process_pkg::*;

  localparam int ADDR_W = 14, FRM_W = 8, NUM_CH = 2, STRIDE = 256, RST_CYC = 3, TO_W = 6;

  logic              clk_in = 1'b0, rst_n = 1'b0;
  logic              start_sys = 1'b0, intr_clr_sys = 1'b0, abort_sys = 1'b0;
  logic [ADDR_W-1:0] start_music_addr = '0;
  logic [FRM_W-1:0]  num_frames = '0;
  logic [1:0]        mode = '0;
  logic              finish_mdct = 1'b0, finish_imdct = 1'b0;
  logic              start_clr_sys, intr_sys, err_sys, busy, start_mdct, start_imdct, rstn_mdct, rstn_imdct;
  logic [FRM_W-1:0]  frame_idx;
  logic [2:0]        ch_idx;
  logic [ADDR_W-1:0] start_music_addr_r;

  always #5 clk_in = ~clk_in;

  process_seq #(.ADDR_W(ADDR_W), .FRM_W(FRM_W), .NUM_CH(NUM_CH), .FRAME_STRIDE(STRIDE),
                .RST_CYC(RST_CYC), .TO_W(TO_W)) dut (
    .clk_in(clk_in), .rst_n(rst_n), .start_sys(start_sys), .intr_clr_sys(intr_clr_sys),
    .abort_sys(abort_sys), .start_music_addr(start_music_addr), .num_frames(num_frames),
    .mode(mode), .start_clr_sys(start_clr_sys), .intr_sys(intr_sys), .err_sys(err_sys),
    .busy(busy), .frame_idx(frame_idx), .ch_idx(ch_idx), .start_mdct(start_mdct),
    .start_music_addr_r(start_music_addr_r), .finish_mdct(finish_mdct), .rstn_mdct(rstn_mdct),
    .start_imdct(start_imdct), .finish_imdct(finish_imdct), .rstn_imdct(rstn_imdct)
  );

  typedef struct { int stg; int addr; int dly; } ev_t;
  ev_t exp_q[$];
  int  checks = 0, failures = 0, cyc = 0, ref_cyc = 0, n_clr = 0, n_start = 0;
  int  pend[2];
  bit  chk_seq = 1'b0, resp_en = 1'b0, seen_rm = 1'b0, seen_ri = 1'b0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // One cycle: sample at negedge, emulate AXI ack and the two stages.
  task automatic tick();
    ev_t ev;
    logic st;
    @(negedge clk_in);
    cyc++;
    if (start_clr_sys) begin n_clr++; start_sys = 1'b0; end
    if (rstn_mdct)  seen_rm = 1'b1;
    if (rstn_imdct) seen_ri = 1'b1;
    if (!rstn_mdct)  finish_mdct  = 1'b0;
    if (!rstn_imdct) finish_imdct = 1'b0;
    if (pend[0] > 0) begin pend[0]--; if (pend[0] == 0) begin finish_mdct  = 1'b1; ref_cyc = cyc; end end
    if (pend[1] > 0) begin pend[1]--; if (pend[1] == 0) begin finish_imdct = 1'b1; ref_cyc = cyc; end end
    for (int s = 0; s < 2; s++) begin
      st = (s == 0) ? start_mdct : start_imdct;
      if (st) begin
        n_start++;
        if (chk_seq) begin
          if (exp_q.size() == 0) chk("extra_start", 1, 0);
          else begin
            ev = exp_q.pop_front();
            chk("seq_stage", s, ev.stg);
            chk("seq_addr", start_music_addr_r, ev.addr);
            chk("seq_delay", cyc - ref_cyc, ev.dly);
          end
        end
        if (resp_en) pend[s] = $urandom_range(8, 1);
      end
    end
  endtask

  task automatic clear_irq();
    intr_clr_sys = 1'b1;
    tick();
    intr_clr_sys = 1'b0;
    chk("clr_intr", intr_sys, 0);
    chk("clr_err", err_sys, 0);
    chk("clr_busy", busy, 0);
  endtask

  task automatic launch(input logic [1:0] m, input int nf, input logic [ADDR_W-1:0] base);
    tick();
    mode = m; num_frames = FRM_W'(nf); start_music_addr = base;
    start_sys = 1'b1; ref_cyc = cyc; n_clr = 0; n_start = 0; seen_rm = 0; seen_ri = 0;
  endtask

  // Full run checked against the expected list of stage starts.
  task automatic do_run(input logic [1:0] m, input int nf, input logic [ADDR_W-1:0] base);
    int t0, intr_at, n_exp;
    bit use_m, use_i;
    exp_q.delete();
    if (m != 2'b11)
      for (int f = 0; f < nf; f++)
        for (int c = 0; c < NUM_CH; c++) begin
          int a;
          a = (int'(base) + (f * NUM_CH + c) * STRIDE) % (1 << ADDR_W);
          if (m != 2'b01) exp_q.push_back('{0, a, 2 + RST_CYC});
          if (m == 2'b01) exp_q.push_back('{1, a, 2 + RST_CYC});
          if (m == 2'b10) exp_q.push_back('{1, a, 1 + RST_CYC});
        end
    n_exp = exp_q.size();
    use_m = (m == 2'b00 || m == 2'b10) && nf > 0;
    use_i = (m == 2'b01 || m == 2'b10) && nf > 0;
    chk_seq = 1'b1; resp_en = 1'b1;
    launch(m, nf, base);
    t0 = cyc; intr_at = -1;
    do begin
      tick();
      if (intr_sys && intr_at < 0) intr_at = cyc;
    end while (busy && cyc - t0 < 3000);
    chk("run_end", busy, 0);
    chk("run_intr", intr_sys, 1);
    chk("run_err", err_sys, m == 2'b11);
    chk("run_ack", n_clr, 1);
    chk("run_starts", n_start, n_exp);
    chk("run_left", exp_q.size(), 0);
    chk("run_mdct_used", seen_rm, use_m);
    chk("run_imdct_used", seen_ri, use_i);
    if (nf == 0 || m == 2'b11) chk("run_done_lat", intr_at - t0, 2);
    chk_seq = 1'b0;
    clear_irq();
  endtask

  initial begin
    int k, ts;
    pend[0] = 0; pend[1] = 0;
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_intr", {intr_sys, err_sys, start_clr_sys}, 0);
    chk("rst_stage", {start_mdct, start_imdct, rstn_mdct, rstn_imdct}, 0);
    chk("rst_addr", start_music_addr_r, 0);
    chk("rst_idx", {frame_idx, ch_idx}, 0);
    rst_n = 1'b1;
    tick();

    do_run(2'b10, 2, 14'h0100);
    do_run(2'b01, 1, 14'h0040);
    do_run(2'b00, 0, 14'h0000);
    do_run(2'b11, 2, 14'h0000);
    do_run(2'b00, 1, 14'h3F00);
    for (int r = 0; r < 8; r++)
      do_run(2'($urandom_range(2, 0)), $urandom_range(3, 0), ADDR_W'($urandom()));

    // Watchdog: finish_mdct never rises.
    resp_en = 1'b0;
    launch(MODE_MDCT, 1, 14'h0);
    k = 0;
    while (!start_mdct && k < 50) begin tick(); k++; end
    chk("to_start", start_mdct, 1);
    ts = cyc; k = 0;
    while (!err_sys && k < 200) begin tick(); k++; end
    chk("to_delay", cyc - ts, 1 << TO_W);
    chk("to_intr", intr_sys, 1);
    chk("to_busy", busy, 0);
    chk("to_rstn", rstn_mdct, 0);
    clear_irq();

    // Abort while waiting on mdct.
    launch(MODE_BOTH, 2, 14'h0);
    k = 0;
    while (!start_mdct && k < 50) begin tick(); k++; end
    repeat (5) tick();
    chk("ab_busy_pre", busy, 1);
    abort_sys = 1'b1;
    tick();
    abort_sys = 1'b0;
    chk("ab_busy", busy, 0);
    chk("ab_rstn", rstn_mdct, 0);
    chk("ab_intr", intr_sys, 0);
    repeat (3) tick();
    chk("ab_intr_late", {intr_sys, err_sys}, 0);
    chk("ab_ack_once", n_clr, 1);

    // Clear request coincident with DONE entry loses to the set.
    launch(MODE_MDCT, 0, 14'h0);
    tick();
    chk("ce_ack", start_clr_sys, 1);
    intr_clr_sys = 1'b1;
    tick();
    intr_clr_sys = 1'b0;
    chk("ce_set_wins", intr_sys, 1);
    tick();
    chk("ce_sticky", intr_sys, 1);
    clear_irq();

    // Async reset in the middle of a run.
    resp_en = 1'b1;
    launch(MODE_BOTH, 3, 14'h1234);
    repeat (12) tick();
    chk("ar_busy_pre", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_busy", busy, 0);
    chk("ar_rstn", {rstn_mdct, rstn_imdct}, 0);
    chk("ar_addr", start_music_addr_r, 0);
    chk("ar_idx", {frame_idx, ch_idx}, 0);
    resp_en = 1'b0; pend[0] = 0; pend[1] = 0;
    tick();
    rst_n = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

endmodule

// File: doc/process_seq.md
Name: process_seq

Overview:
- Parametrised multi-frame, multi-channel sequencer for the audio compress/decompress path.
- Sits between the AXI-side control registers and the mdct_top/imdct_top stages.
- Accepts one system start. Then, per frame and channel: soft-resets each stage, pulses its start and waits for its finish.
- Supports three modes and a watchdog timeout. Raises one sticky interrupt when the whole run ends.

Parameters:
ADDR_W, 14, music ROM address width
FRM_W, 8, width of frame-count input
NUM_CH, 2, channels per frame (1..8)
FRAME_STRIDE, 256, ROM words between consecutive channel-frames
RST_CYC, 4, cycles a stage reset is held low before its start (>=1)
TO_W, 16, timeout counter width; timeout fires at 2^TO_W-1 wait cycles

Ports:
clk_in  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start_sys  in  1  level start request from AXI reg
intr_clr_sys  in  1  clears intr_sys/err_sys
abort_sys  in  1  abort current run
start_music_addr  in  ADDR_W  base ROM address
num_frames  in  FRM_W  frames to process
mode  in  2  00 mdct only, 01 imdct only, 10 mdct then imdct, 11 illegal
start_clr_sys  out  1  one-cycle ack; AXI clears start reg
intr_sys  out  1  sticky done interrupt
err_sys  out  1  sticky error flag (timeout / illegal mode)
busy  out  1  high outside IDLE/DONE/ERR
frame_idx  out  FRM_W  current frame
ch_idx  out  3  current channel
start_mdct  out  1  one-cycle start pulse
start_music_addr_r  out  ADDR_W  address for current channel-frame
finish_mdct  in  1  mdct intr (level)
rstn_mdct  out  1  mdct soft reset, active low
start_imdct  out  1  one-cycle start pulse
finish_imdct  in  1  imdct intr (level)
rstn_imdct  out  1  imdct soft reset, active low

Behaviour:
- Reset values: all outputs 0; rstn_mdct/rstn_imdct 0; state IDLE.
- States: IDLE, ACK, RST_M, START_M, WAIT_M, RST_I, START_I, WAIT_I, NEXT, DONE, ERR.
- IDLE: both stage resets low. start_sys=1 -> ACK.
- ACK (1 cycle):
  - start_clr_sys=1.
  - Latch base address, num_frames and mode; frame_idx=ch_idx=0.
  - mode 11 -> ERR. num_frames=0 -> DONE.
  - mode 01 -> RST_I; otherwise -> RST_M.
- RST_x: rstn_x=0 for exactly RST_CYC cycles, then START_x.
- START_x: rstn_x=1, start_x=1 for one cycle -> WAIT_x.
- WAIT_x:
  - rstn_x=1. Advance on the rising edge of finish_x (registered previous value; a level already high on entry does not count).
  - WAIT_M: mode 10 -> RST_I, else -> NEXT. WAIT_I -> NEXT.
  - Timeout counter clears on entry; reaching all-ones -> ERR.
- NEXT (1 cycle): ch_idx++. At NUM_CH-1, ch_idx=0 and frame_idx++. At last frame -> DONE; else -> RST_M (mode 00/10) or RST_I (mode 01).
- start_music_addr_r = base + (frame_idx*NUM_CH + ch_idx)*FRAME_STRIDE, truncated to ADDR_W (wraps mod 2^ADDR_W). Registered; valid from START_x.
- DONE: intr_sys=1, both resets low; stays until intr_clr_sys -> IDLE (intr_sys cleared the same edge).
- ERR: intr_sys=1, err_sys=1, both resets low; intr_clr_sys clears both and -> IDLE.
- abort_sys in any busy state: next cycle IDLE, both resets low, no interrupt, start_clr_sys not re-asserted.
- Priority: abort_sys > timeout > finish edge.
- intr_clr_sys in the cycle the FSM enters DONE/ERR: the set wins.
- start_sys outside IDLE: ignored. start_sys still high on return to IDLE: a new run starts (AXI must honour start_clr_sys).
- Async reset mid-run: everything returns to reset values immediately.
- Latency: start_sys edge to first start_mdct = 2+RST_CYC cycles.

Decomposition:
- Package process_pkg: state enum, mode encodings (MODE_MDCT, MODE_IMDCT, MODE_BOTH), and the default parameter constants.
- One sub-module, stage_handshake: reset-hold counter, start pulse, finish edge detect and timeout. Instantiated twice (mdct, imdct).
- The top FSM sequences the two instances and owns the frame/channel counters and address arithmetic.

Test Plan:
1. mode=10, num_frames=2, NUM_CH=2, base=0x0100, stages answer finish 20 cycles after start -> 8 start pulses (4 mdct, 4 imdct, alternating); addresses 0x0100, 0x0200, 0x0300, 0x0400; intr_sys=1, err_sys=0; start_clr_sys exactly one pulse.
2. mode=01, num_frames=1 -> only start_imdct pulses (2); rstn_mdct stays 0 throughout; intr_sys=1.
3. num_frames=0 -> intr_sys=1 two cycles after start_sys, no stage start; mode=11 -> err_sys=1, intr_sys=1, no start.
4. Base=0x3F00, FRAME_STRIDE=256, 2 channel-frames -> addresses 0x3F00 then 0x0000 (wrap).
5. finish_mdct never rises, TO_W=6 -> ERR after 63 wait cycles; err_sys=1; intr_clr_sys -> both flags 0, IDLE.
6. abort_sys mid WAIT_M -> IDLE next cycle, rstn_mdct=0, intr_sys=0. intr_clr_sys asserted in the DONE-entry cycle -> intr_sys stays 1.
